lc3_ctrl_exec: RTL and testbench
================================

# lc3_ctrl_exec

Control-and-execute core of the LC-3 processor: a multicycle Moore state machine, the 8×16 general-purpose register file and the 16-bit ALU. It decodes the instruction register (IR) and condition codes supplied by the LC-3 top level, and drives every gate, load and mux select of the shared bus datapath. It exposes the register-read and ALU results to that datapath. Memory, MAR/MDR/PC/IR/NZP registers and the bus itself live in the top level.

## Interface
- No parameters.
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock (top gates it with ~HALT)
- rst  in  1  asynchronous, active-low reset
- IR  in  16  current instruction
- NZP  in  3  condition codes {N,Z,P}
- BUS  in  16  shared bus; register write data
- HALT  out  1  registered; high once TRAP x25 executes
- LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_PC  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high
- PCMUX  out  2  00 PC+1, 01 address adder, 10 BUS
- ADDR1MUX  out  1  0 PC, 1 SR1_OUT
- ADDR2MUX  out  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]
- MARMUX  out  1  0 zext IR[7:0], 1 address adder
- ALUK  out  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A
- MEM_EN, R_W  out  1 each  memory enable / write (1 = write)
- SR2MUX  out  1  1 selects sext IR[4:0] as ALU B
- DR, SR1, SR2  out  3 each  register selects
- SR1_OUT, SR2_OUT  out  16 each  combinational register reads
- ALU_OUT  out  16  combinational ALU result

## Operation
- Register file: R0–R7 cleared by reset; write BUS→R[DR] on rising edge when LD_REG; reads are asynchronous. A same-cycle read of the register being written returns the old value.
- ALU: A=SR1_OUT; B=SR2MUX ? sext(IR[4:0]) : SR2_OUT. ADD wraps mod 2^16.
- Defaults in every state: all loads, gates and MEM_EN/R_W are 0; SR1=IR[8:6]; SR2=IR[2:0]; DR=IR[11:9].
- FETCH1: GatePC, LD_MAR, LD_PC, PCMUX=00.
- FETCH2: MEM_EN, LD_MDR (read).
- FETCH3: GateMDR, LD_IR.
- DECODE: no controls asserted. Next state is selected by IR[15:12].
- ADD(0001)/AND(0101)/NOT(1001): one state with GateALU, LD_REG, LD_CC, ALUK=00/01/10, SR2MUX=IR[5] (0 for NOT).
- BR(0000): if (IR[11:9] & NZP) ≠ 0, assert LD_PC, PCMUX=01, ADDR1MUX=0, ADDR2MUX=10. Otherwise no controls. One state.
- JMP(1100): LD_PC, PCMUX=01, ADDR1MUX=1, ADDR2MUX=00.
- JSR/JSRR(0100): one state with GatePC, LD_REG, DR=7, LD_PC, PCMUX=01.
  - IR[11]=1: ADDR1MUX=0, ADDR2MUX=11.
  - IR[11]=0: ADDR1MUX=1, ADDR2MUX=00.
- LEA(1110): GateMARMUX, MARMUX=1, ADDR1MUX=0, ADDR2MUX=10, LD_REG. CC is not updated.
- LD(0010)/LDR(0110)/LDI(1010):
  - ADDR: GateMARMUX, MARMUX=1, LD_MAR. LD/LDI use ADDR1MUX=0, ADDR2MUX=10; LDR uses ADDR1MUX=1, ADDR2MUX=01.
  - LDI only: READ, then GateMDR+LD_MAR.
  - READ, then WB: GateMDR, LD_REG, LD_CC.
- ST(0011)/STR(0111)/STI(1011):
  - ADDR as for the corresponding load.
  - STI only: READ, then GateMDR+LD_MAR.
  - DATA: SR1=IR[11:9], ALUK=11, GateALU, LD_MDR, MEM_EN=0.
  - WRITE: MEM_EN=1, R_W=1.
- TRAP(1111), IR[7:0]≠x25:
  - T1: GateMARMUX, MARMUX=0, LD_MAR.
  - T2: GatePC, LD_REG, DR=7.
  - T3: READ.
  - T4: GateMDR, LD_PC, PCMUX=10.
- TRAP x25: HALT state. HALT register set, state holds, all other controls 0.
- RTI(1000) and reserved(1101) execute as NOP and go back to FETCH1.
- Every last execute state returns to FETCH1.

## Timing
- Async reset (rst=0): state=FETCH1, HALT=0, R0–R7=0. While in reset, outputs show the FETCH1 decode.
- Controls are a Moore decode of state plus IR/NZP, stable across the cycle. Transitions occur on the rising clk edge.
- Instruction latency in cycles, including fetch and decode:
  - 5: ADD, AND, NOT, BR, JMP, JSR, LEA, RTI/reserved.
  - 7: LD, LDR, ST, STR.
  - 9: LDI, STI.
  - 8: TRAP.
- A memory read needs MAR loaded in the previous cycle; MDR captures on the READ edge.
- HALT stays high until rst falls, even though clk stops.

## Test plan
- Reset: pulse rst low mid-instruction, release → GatePC=LD_MAR=LD_PC=1, PCMUX=00, HALT=0, SR1_OUT=SR2_OUT=0 for all selects.
- Write then execute:
  - Write R1=5 via BUS/LD_REG path, IR=0x1261 → cycle 5: SR2MUX=1, ALUK=00, DR=1, GateALU, LD_REG, LD_CC, ALU_OUT=6.
  - ADD wrap: R1=0xFFFF + imm 1 → ALU_OUT=0x0000.
- AND/NOT:
  - R2=0x00FF, R3=0x0F0F, IR=0x5483 → ALU_OUT=0x000F.
  - IR=0x94BF (NOT R2) → ALU_OUT=0xFF00.
- Branch: IR=0x0405 (BRz).
  - NZP=010 → execute cycle LD_PC=1, PCMUX=01, ADDR2MUX=10.
  - NZP=001 → LD_PC=0, back to FETCH1 next cycle.
- LDI IR=0xA202 → ADDR(LD_MAR), READ(MEM_EN, LD_MDR), GateMDR+LD_MAR, READ, WB(GateMDR, LD_REG, DR=1, LD_CC). 9 cycles total.
- Store and halt:
  - STI IR=0xB202 → DATA state has R_W=0, MEM_EN=0, ALUK=11, SR1=1; then exactly one cycle with MEM_EN=R_W=1.
  - IR=0xF025 → HALT=1 after DECODE and stays set until rst is asserted low.

Source files
------------

// File: rtl/lc3_ctrl_exec.sv
// rtl/lc3_ctrl_exec.sv - LC-3 control FSM, 8x16 register file and ALU
module lc3_ctrl_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
    input  logic [15:0] BUS,
    output logic        HALT,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic        MARMUX,
    output logic [1:0]  ALUK,
    output logic        MEM_EN,
    output logic        R_W,
    output logic        SR2MUX,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [15:0] SR1_OUT,
    output logic [15:0] SR2_OUT,
    output logic [15:0] ALU_OUT
);

    // Load/store share one address/read/indirect path; IR[12] picks store,
    // IR[15] picks the indirect variant, IR[14] picks base+offset6.
    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ALU, S_BR, S_JMP, S_JSR, S_LEA, S_NOP,
        S_ADDR, S_IREAD, S_IADDR, S_READ, S_WB, S_DATA, S_WRITE,
        S_TRAP1, S_TRAP2, S_TRAP3, S_TRAP4, S_HALT
    } state_t;

    state_t      state;
    logic [3:0]  opcode;
    logic [15:0] regs [8];
    logic [15:0] alu_b;

    assign opcode = IR[15:12];

    // State sequencing and the sticky HALT flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH1;
            HALT  <= 1'b0;
        end else begin
            case (state)
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: state <= S_FETCH3;
                S_FETCH3: state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        4'b0001, 4'b0101, 4'b1001: state <= S_ALU;
                        4'b0000: state <= S_BR;
                        4'b1100: state <= S_JMP;
                        4'b0100: state <= S_JSR;
                        4'b1110: state <= S_LEA;
                        4'b0010, 4'b0110, 4'b1010,
                        4'b0011, 4'b0111, 4'b1011: state <= S_ADDR;
                        4'b1111: begin
                            if (IR[7:0] == 8'h25) begin
                                state <= S_HALT;
                                HALT  <= 1'b1;
                            end else begin
                                state <= S_TRAP1;
                            end
                        end
                        default: state <= S_NOP;
                    endcase
                end
                S_ADDR:  state <= IR[15] ? S_IREAD : (IR[12] ? S_DATA : S_READ);
                S_IREAD: state <= S_IADDR;
                S_IADDR: state <= IR[12] ? S_DATA : S_READ;
                S_READ:  state <= S_WB;
                S_DATA:  state <= S_WRITE;
                S_TRAP1: state <= S_TRAP2;
                S_TRAP2: state <= S_TRAP3;
                S_TRAP3: state <= S_TRAP4;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH1;
            endcase
        end
    end

    // Register file: cleared by reset, written from the bus on LD_REG.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (LD_REG) begin
            regs[DR] <= BUS;
        end
    end

    assign SR1_OUT = regs[SR1];
    assign SR2_OUT = regs[SR2];
    assign alu_b   = SR2MUX ? {{11{IR[4]}}, IR[4:0]} : SR2_OUT;

    // ALU: ADD, AND, NOT A, PASS A.
    always_comb begin
        case (ALUK)
            2'b00:   ALU_OUT = SR1_OUT + alu_b;
            2'b01:   ALU_OUT = SR1_OUT & alu_b;
            2'b10:   ALU_OUT = ~SR1_OUT;
            default: ALU_OUT = SR1_OUT;
        endcase
    end

    // Moore control decode from state, IR and NZP.
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_REG     = 1'b0;
        LD_CC      = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        MARMUX     = 1'b0;
        ALUK       = 2'b00;
        MEM_EN     = 1'b0;
        R_W        = 1'b0;
        SR2MUX     = 1'b0;
        SR1        = IR[8:6];
        SR2        = IR[2:0];
        DR         = IR[11:9];
        case (state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_FETCH2, S_IREAD, S_READ, S_TRAP3: begin
                MEM_EN = 1'b1;
                LD_MDR = 1'b1;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_ALU: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                case (opcode)
                    4'b0101: begin
                        ALUK   = 2'b01;
                        SR2MUX = IR[5];
                    end
                    4'b1001: ALUK = 2'b10;
                    default: begin
                        ALUK   = 2'b00;
                        SR2MUX = IR[5];
                    end
                endcase
            end
            S_BR: begin
                if ((IR[11:9] & NZP) != 3'b000) begin
                    LD_PC    = 1'b1;
                    PCMUX    = 2'b01;
                    ADDR2MUX = 2'b10;
                end
            end
            S_JMP: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b01;
                ADDR1MUX = 1'b1;
            end
            S_JSR: begin
                GatePC = 1'b1;
                LD_REG = 1'b1;
                DR     = 3'd7;
                LD_PC  = 1'b1;
                PCMUX  = 2'b01;
                if (IR[11]) begin
                    ADDR2MUX = 2'b11;
                end else begin
                    ADDR1MUX = 1'b1;
                end
            end
            S_LEA: begin
                GateMARMUX = 1'b1;
                MARMUX     = 1'b1;
                ADDR2MUX   = 2'b10;
                LD_REG     = 1'b1;
            end
            S_ADDR: begin
                GateMARMUX = 1'b1;
                MARMUX     = 1'b1;
                LD_MAR     = 1'b1;
                if (IR[14]) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b01;
                end else begin
                    ADDR2MUX = 2'b10;
                end
            end
            S_IADDR: begin
                GateMDR = 1'b1;
                LD_MAR  = 1'b1;
            end
            S_WB: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_DATA: begin
                SR1     = IR[11:9];
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_WRITE: begin
                MEM_EN = 1'b1;
                R_W    = 1'b1;
            end
            S_TRAP1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_TRAP2: begin
                GatePC = 1'b1;
                LD_REG = 1'b1;
                DR     = 3'd7;
            end
            S_TRAP4: begin
                GateMDR = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl_exec.sv
// tb/tb_lc3_ctrl_exec.sv - scoreboard bench for lc3_ctrl_exec
module tb_lc3_ctrl_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR;
    logic [2:0]  NZP;
    logic [15:0] BUS;
    logic        HALT, LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, MARMUX, MEM_EN, R_W, SR2MUX;
    logic [2:0]  DR, SR1, SR2;
    logic [15:0] SR1_OUT, SR2_OUT, ALU_OUT;

    lc3_ctrl_exec dut (
        .clk(clk), .rst(rst), .IR(IR), .NZP(NZP), .BUS(BUS), .HALT(HALT),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_REG(LD_REG),
        .LD_CC(LD_CC), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR),
        .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
        .MEM_EN(MEM_EN), .R_W(R_W), .SR2MUX(SR2MUX), .DR(DR), .SR1(SR1),
        .SR2(SR2), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .ALU_OUT(ALU_OUT)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] C_LD_MAR = 32'h001, C_LD_MDR = 32'h002, C_LD_IR  = 32'h004;
    localparam logic [31:0] C_LD_REG = 32'h008, C_LD_CC  = 32'h010, C_LD_PC  = 32'h020;
    localparam logic [31:0] C_G_PC   = 32'h040, C_G_MDR  = 32'h080, C_G_ALU  = 32'h100;
    localparam logic [31:0] C_G_MM   = 32'h200, C_MEM    = 32'h400, C_RW     = 32'h800;
    localparam logic [31:0] M_CTL = 32'h00FFF, M_PCMUX = 32'h03000, M_A1 = 32'h04000;
    localparam logic [31:0] M_A2  = 32'h18000, M_MM = 32'h20000, M_ALUK = 32'hC0000;
    localparam logic [31:0] M_SR2 = 32'h100000;
    localparam logic [31:0] FETCH_SIG = C_G_PC | C_LD_MAR | C_LD_PC;
    localparam int O_CTL = 0, O_ALU = 1, O_DR = 2, O_SR1 = 3, O_HALT = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pcm(input logic [1:0] v);
        return {18'b0, v, 12'b0};
    endfunction
    function automatic logic [31:0] a2m(input logic [1:0] v);
        return {15'b0, v, 15'b0};
    endfunction
    function automatic logic [31:0] alk(input logic [1:0] v);
        return {12'b0, v, 18'b0};
    endfunction

    function automatic logic [31:0] ctl();
        return {11'b0, SR2MUX, ALUK, MARMUX, ADDR2MUX, ADDR1MUX, PCMUX, R_W, MEM_EN,
                GateMARMUX, GateALU, GateMDR, GatePC, LD_PC, LD_CC, LD_REG, LD_IR,
                LD_MDR, LD_MAR};
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            O_CTL:   return ctl();
            O_ALU:   return {16'b0, ALU_OUT};
            O_DR:    return {29'b0, DR};
            O_SR1:   return {29'b0, SR1};
            default: return {31'b0, HALT};
        endcase
    endfunction

    task automatic expect_at(input string tag, input int cyc, input int sel,
                             input logic [31:0] exp, input logic [31:0] mask);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.exp = exp; e.mask = mask;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Cycle 1 is FETCH1; expectations are popped as their cycle comes up.
    task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp,
                             input logic [15:0] bus, input int ncyc, input bit ret);
        exp_t  e;
        string t;
        IR = ir; NZP = nzp; BUS = bus;
        if (ret) expect_at("return_fetch", ncyc + 1, O_CTL, FETCH_SIG, M_CTL | M_PCMUX);
        #1;
        for (int c = 1; c <= ncyc + 1; c++) begin
            while (sb.size() > 0 && sb[0].cyc <= c) begin
                e = sb.pop_front();
                t = sb_tag.pop_front();
                check(t, obs(e.sel) & e.mask, e.exp & e.mask);
            end
            if (c <= ncyc) begin
                @(posedge clk);
                #1;
            end
        end
        if (sb.size() != 0) begin
            check("sb_leftover", sb.size(), 0);
            sb.delete();
            sb_tag.delete();
        end
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
        expect_at("lea_ctl", 5, O_CTL, C_G_MM | C_LD_REG | M_MM | a2m(2'b10),
                  M_CTL | M_MM | M_A1 | M_A2);
        expect_at("lea_dr", 5, O_DR, {29'b0, r}, 32'h7);
        run_instr({4'hE, r, 9'h000}, 3'b000, v, 5, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; IR = 16'h0000; NZP = 3'b000; BUS = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", ctl() & (M_CTL | M_PCMUX), FETCH_SIG);
        check("reset_halt", HALT, 1'b0);
        rst = 1'b1;

        write_reg(3'd1, 16'h1234);

        // Reset pulse in the middle of an ADD fetch.
        IR = 16'h1261;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("midrst_ctl", ctl() & (M_CTL | M_PCMUX), FETCH_SIG);
        check("midrst_halt", HALT, 1'b0);
        for (int i = 0; i < 8; i++) begin
            IR = 16'((i << 6) | i);
            #1;
            check($sformatf("midrst_sr1_out%0d", i), SR1_OUT, 16'h0000);
            check($sformatf("midrst_sr2_out%0d", i), SR2_OUT, 16'h0000);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // ADD immediate
        write_reg(3'd1, 16'h0005);
        expect_at("add_ctl", 5, O_CTL, C_G_ALU | C_LD_REG | C_LD_CC | M_SR2 | alk(2'b00),
                  M_CTL | M_SR2 | M_ALUK);
        expect_at("add_dr", 5, O_DR, 32'd1, 32'h7);
        expect_at("add_alu", 5, O_ALU, 32'h0006, 32'hFFFF);
        run_instr(16'h1261, 3'b000, 16'h0006, 5, 1'b1);

        // ADD wrap
        write_reg(3'd1, 16'hFFFF);
        expect_at("addwrap_alu", 5, O_ALU, 32'h0000, 32'hFFFF);
        run_instr(16'h1261, 3'b000, 16'h0000, 5, 1'b1);

        // AND register
        write_reg(3'd2, 16'h00FF);
        write_reg(3'd3, 16'h0F0F);
        expect_at("and_ctl", 5, O_CTL, C_G_ALU | C_LD_REG | C_LD_CC | alk(2'b01),
                  M_CTL | M_SR2 | M_ALUK);
        expect_at("and_alu", 5, O_ALU, 32'h000F, 32'hFFFF);
        run_instr(16'h5483, 3'b000, 16'h000F, 5, 1'b1);

        // NOT
        write_reg(3'd2, 16'h00FF);
        expect_at("not_ctl", 5, O_CTL, C_G_ALU | C_LD_REG | C_LD_CC | alk(2'b10),
                  M_CTL | M_SR2 | M_ALUK);
        expect_at("not_alu", 5, O_ALU, 32'hFF00, 32'hFFFF);
        run_instr(16'h94BF, 3'b000, 16'hFF00, 5, 1'b1);

        // BRz taken and not taken
        expect_at("brz_taken", 5, O_CTL, C_LD_PC | pcm(2'b01) | a2m(2'b10),
                  M_CTL | M_PCMUX | M_A1 | M_A2);
        run_instr(16'h0405, 3'b010, 16'h0000, 5, 1'b1);
        expect_at("brz_not_taken", 5, O_CTL, 32'h0, M_CTL);
        run_instr(16'h0405, 3'b001, 16'h0000, 5, 1'b1);

        // JMP R7, JSR offset
        expect_at("jmp_ctl", 5, O_CTL, C_LD_PC | pcm(2'b01) | M_A1 | a2m(2'b00),
                  M_CTL | M_PCMUX | M_A1 | M_A2);
        run_instr(16'hC1C0, 3'b000, 16'h0000, 5, 1'b1);
        expect_at("jsr_ctl", 5, O_CTL, C_G_PC | C_LD_REG | C_LD_PC | pcm(2'b01) | a2m(2'b11),
                  M_CTL | M_PCMUX | M_A1 | M_A2);
        expect_at("jsr_dr", 5, O_DR, 32'd7, 32'h7);
        run_instr(16'h4800, 3'b000, 16'h3001, 5, 1'b1);

        // LDI R1 -> loads 0x0042
        expect_at("ldi_addr", 5, O_CTL, C_G_MM | C_LD_MAR | M_MM | a2m(2'b10),
                  M_CTL | M_MM | M_A1 | M_A2);
        expect_at("ldi_read1", 6, O_CTL, C_MEM | C_LD_MDR, M_CTL);
        expect_at("ldi_ind", 7, O_CTL, C_G_MDR | C_LD_MAR, M_CTL);
        expect_at("ldi_read2", 8, O_CTL, C_MEM | C_LD_MDR, M_CTL);
        expect_at("ldi_wb", 9, O_CTL, C_G_MDR | C_LD_REG | C_LD_CC, M_CTL);
        expect_at("ldi_dr", 9, O_DR, 32'd1, 32'h7);
        run_instr(16'hA202, 3'b000, 16'h0042, 9, 1'b1);

        // LDR address mux
        expect_at("ldr_addr", 5, O_CTL, C_G_MM | C_LD_MAR | M_MM | M_A1 | a2m(2'b01),
                  M_CTL | M_MM | M_A1 | M_A2);
        expect_at("ldr_wb", 7, O_CTL, C_G_MDR | C_LD_REG | C_LD_CC, M_CTL);
        run_instr(16'h6281, 3'b000, 16'h0042, 7, 1'b1);

        // STI R1 stores the value loaded above
        expect_at("sti_addr", 5, O_CTL, C_G_MM | C_LD_MAR, M_CTL);
        expect_at("sti_read", 6, O_CTL, C_MEM | C_LD_MDR, M_CTL);
        expect_at("sti_ind", 7, O_CTL, C_G_MDR | C_LD_MAR, M_CTL);
        expect_at("sti_data", 8, O_CTL, C_G_ALU | C_LD_MDR | alk(2'b11), M_CTL | M_ALUK);
        expect_at("sti_sr1", 8, O_SR1, 32'd1, 32'h7);
        expect_at("sti_data_alu", 8, O_ALU, 32'h0042, 32'hFFFF);
        expect_at("sti_write", 9, O_CTL, C_MEM | C_RW, M_CTL);
        run_instr(16'hB202, 3'b000, 16'h0000, 9, 1'b1);

        // TRAP x23
        expect_at("trap_t1", 5, O_CTL, C_G_MM | C_LD_MAR, M_CTL | M_MM);
        expect_at("trap_t2", 6, O_CTL, C_G_PC | C_LD_REG, M_CTL);
        expect_at("trap_t2_dr", 6, O_DR, 32'd7, 32'h7);
        expect_at("trap_t3", 7, O_CTL, C_MEM | C_LD_MDR, M_CTL);
        expect_at("trap_t4", 8, O_CTL, C_G_MDR | C_LD_PC | pcm(2'b10), M_CTL | M_PCMUX);
        run_instr(16'hF023, 3'b000, 16'h0400, 8, 1'b1);

        // TRAP x25 halts
        expect_at("halt_decode", 4, O_HALT, 32'd0, 32'h1);
        expect_at("halt_set", 5, O_HALT, 32'd1, 32'h1);
        expect_at("halt_ctl", 5, O_CTL, 32'h0, M_CTL);
        expect_at("halt_hold", 8, O_HALT, 32'd1, 32'h1);
        expect_at("halt_hold_ctl", 8, O_CTL, 32'h0, M_CTL);
        run_instr(16'hF025, 3'b000, 16'h0000, 8, 1'b0);

        #2;
        rst = 1'b0;
        #1;
        check("halt_cleared", HALT, 1'b0);
        check("halt_rst_ctl", ctl() & (M_CTL | M_PCMUX), FETCH_SIG);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
